// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one ROM word per cycle and
// sequences NOP delays, JMP redirects and BLE resolution with the execute stage.
module fetch_sequencer #(
  parameter logic [3:0] NOP_OP = 4'h5,
  parameter logic [3:0] JMP_OP = 4'h6,
  parameter logic [3:0] BLE_OP = 4'h7
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iStall,
  input  logic        iBranchResolved,
  input  logic        iBranchTaken,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DELAY,
    S_BR_WAIT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [23:0] r_count;
  logic [15:0] r_target;
  logic [27:0] r_instr;
  logic        r_valid;

  logic [3:0]  w_opcode;
  logic [15:0] w_target;
  logic [23:0] w_count;

  assign w_opcode = iInstruction[27:24];
  assign w_target = {8'd0, iInstruction[23:16]};
  assign w_count  = iInstruction[23:0];

  // Stall freezes every register, including a pending branch resolution.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= S_RUN;
      r_pc     <= '0;
      r_count  <= '0;
      r_target <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
    end else if (!iStall) begin
      case (r_state)
        S_RUN: begin
          r_instr <= iInstruction;
          r_valid <= 1'b1;
          r_pc    <= r_pc + 16'd1;
          if (w_opcode == NOP_OP) begin
            if (w_count != '0) begin
              r_count <= w_count;
              r_state <= S_DELAY;
            end
          end else if (w_opcode == JMP_OP) begin
            r_pc <= w_target;
          end else if (w_opcode == BLE_OP) begin
            r_target <= w_target;
            r_state  <= S_BR_WAIT;
          end
        end
        S_DELAY: begin
          r_valid <= 1'b0;
          r_count <= r_count - 24'd1;
          if (r_count == 24'd1) begin
            r_state <= S_RUN;
          end
        end
        S_BR_WAIT: begin
          r_valid <= 1'b0;
          if (iBranchResolved) begin
            if (iBranchTaken) begin
              r_pc <= r_target;
            end
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oAddress     = r_pc;
  assign oInstruction = r_instr;
  assign oValid       = r_valid;
  assign oBusy        = (r_state == S_DELAY) || (r_state == S_BR_WAIT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each scenario queues per-edge stimulus
// with the outputs expected after that edge, then drains and compares.
module tb_fetch_sequencer;

  localparam logic [3:0] NOP = 4'h5;
  localparam logic [3:0] JMP = 4'h6;
  localparam logic [3:0] BLE = 4'h7;
  localparam logic [3:0] STO = 4'h1;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iStall = 1'b0;
  logic        iBranchResolved = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic        oBusy;

  logic [27:0] rom [0:65535];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        rst, stall, res, tkn;
    logic [15:0] a;
    logic        v;
    logic [27:0] ins;
    logic        b;
  } ent_t;

  ent_t sb[$];
  ent_t e;

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  fetch_sequencer #(
    .NOP_OP(NOP),
    .JMP_OP(JMP),
    .BLE_OP(BLE)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .oAddress(oAddress),
    .iInstruction(iInstruction),
    .oInstruction(oInstruction),
    .oValid(oValid),
    .iStall(iStall),
    .iBranchResolved(iBranchResolved),
    .iBranchTaken(iBranchTaken),
    .oBusy(oBusy)
  );

  function automatic logic [27:0] w(input logic [3:0] op, input logic [23:0] arg);
    return {op, arg};
  endfunction

  // stimulus for the next edge, then outputs expected after it
  function automatic void push(input logic rst, input logic stall, input logic res,
                               input logic tkn, input logic [15:0] a, input logic v,
                               input logic [27:0] ins, input logic b);
    ent_t x;
    x.rst = rst; x.stall = stall; x.res = res; x.tkn = tkn;
    x.a = a; x.v = v; x.ins = ins; x.b = b;
    sb.push_back(x);
  endfunction

  function automatic void clear_rom();
    for (int unsigned i = 0; i < 32; i++) rom[i] = '0;
    rom[16'hFFFE] = '0;
    rom[16'hFFFF] = '0;
  endfunction

  task automatic test_reset();
    clear_rom();
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(1, 1, 1, 1, 16'd0, 0, 28'd0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL reset: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_straight();
    clear_rom();
    for (int unsigned i = 0; i < 4; i++) rom[i] = w(STO, 24'h000100 + 24'(i));
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    for (int unsigned i = 0; i < 4; i++)
      push(0, 0, 0, 0, 16'(i + 1), 1, rom[i], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL straight: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_nop();
    clear_rom();
    rom[0] = w(NOP, 24'd3);
    rom[1] = w(STO, 24'h00AA01);
    rom[2] = w(NOP, 24'd0);
    rom[3] = w(STO, 24'h00AA03);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd1, 1, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 0);
    push(0, 0, 0, 0, 16'd2, 1, rom[1], 0);
    push(0, 0, 0, 0, 16'd3, 1, rom[2], 0);
    push(0, 0, 0, 0, 16'd4, 1, rom[3], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL nop_delay: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[0]  = w(JMP, {8'd14, 16'h0000});
    rom[14] = w(JMP, {8'd2, 16'h0000});
    rom[2]  = w(STO, 24'h00BB02);
    rom[3]  = w(STO, 24'h00BB03);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd14, 1, rom[0], 0);
    push(0, 0, 0, 0, 16'd2, 1, rom[14], 0);
    push(0, 0, 0, 0, 16'd3, 1, rom[2], 0);
    push(0, 0, 0, 0, 16'd4, 1, rom[3], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL jmp: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_ble();
    clear_rom();
    rom[0]  = w(JMP, {8'd9, 16'h0000});
    rom[9]  = w(BLE, {8'd8, 16'h1234});
    rom[8]  = w(STO, 24'h00CC08);
    rom[10] = w(STO, 24'h00CC0A);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd9, 1, rom[0], 0);
    push(0, 0, 0, 0, 16'd10, 1, rom[9], 1);
    push(0, 0, 0, 1, 16'd10, 0, rom[9], 1);
    push(0, 0, 1, 1, 16'd8, 0, rom[9], 0);
    push(0, 0, 0, 0, 16'd9, 1, rom[8], 0);
    push(0, 0, 0, 0, 16'd10, 1, rom[9], 1);
    push(0, 0, 1, 0, 16'd10, 0, rom[9], 0);
    push(0, 0, 0, 0, 16'd11, 1, rom[10], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL ble: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_stall_delay();
    clear_rom();
    rom[0] = w(NOP, 24'd5);
    rom[1] = w(STO, 24'h00DD01);
    rom[2] = w(STO, 24'h00DD02);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd1, 1, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    for (int unsigned i = 0; i < 4; i++) push(0, 1, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 0);
    push(0, 0, 0, 0, 16'd2, 1, rom[1], 0);
    push(0, 1, 0, 0, 16'd2, 1, rom[1], 0);
    push(0, 0, 0, 0, 16'd3, 1, rom[2], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL stall_delay: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_stall_resolve();
    clear_rom();
    rom[0] = w(BLE, {8'd5, 16'h0102});
    rom[1] = w(STO, 24'h00EE01);
    rom[5] = w(STO, 24'h00EE05);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd1, 1, rom[0], 1);
    push(0, 1, 1, 1, 16'd1, 1, rom[0], 1);
    push(0, 1, 1, 1, 16'd1, 1, rom[0], 1);
    push(0, 0, 1, 1, 16'd5, 0, rom[0], 0);
    push(0, 0, 0, 0, 16'd6, 1, rom[5], 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL stall_resolve: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_reset_in_branch();
    clear_rom();
    rom[0] = w(BLE, {8'd8, 16'h0304});
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd1, 1, rom[0], 1);
    push(0, 0, 0, 0, 16'd1, 0, rom[0], 1);
    push(1, 0, 1, 1, 16'd0, 0, 28'd0, 0);
    push(0, 0, 0, 0, 16'd1, 1, rom[0], 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
      @(posedge Clock); #1;
      checks++;
      if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
        $display("FAIL reset_in_branch: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                 oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
      else passed++;
    end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[16'hFFFF] = w(STO, 24'h00FFFF);
    push(1, 0, 0, 0, 16'd0, 0, 28'd0, 0);
    for (int unsigned k = 0; k < 3; k++) begin
      if (k == 1) begin
        Reset = 1'b0; iStall = 1'b0; iBranchResolved = 1'b0; iBranchTaken = 1'b0;
        repeat (65534) @(posedge Clock);
        push(0, 0, 0, 0, 16'hFFFF, 1, 28'd0, 0);
        push(0, 0, 0, 0, 16'h0000, 1, rom[16'hFFFF], 0);
      end
      while (sb.size() > 0 && (k != 0 || sb[0].rst)) begin
        e = sb.pop_front();
        Reset = e.rst; iStall = e.stall; iBranchResolved = e.res; iBranchTaken = e.tkn;
        @(posedge Clock); #1;
        checks++;
        if (oAddress !== e.a || oValid !== e.v || oInstruction !== e.ins || oBusy !== e.b)
          $display("FAIL pc_wrap: got a=%h v=%b i=%h b=%b want a=%h v=%b i=%h b=%b",
                   oAddress, oValid, oInstruction, oBusy, e.a, e.v, e.ins, e.b);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) rom[i] = '0;
    test_reset();
    test_straight();
    test_nop();
    test_jmp();
    test_ble();
    test_stall_delay();
    test_stall_resolve();
    test_reset_in_branch();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
